// File: rtl/npu_sched_pkg.sv
// Shared types and widths for the conv NPU layer scheduler.
package npu_sched_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LCNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    // Whole-layer conv command as written by the host.
    typedef struct packed {
        logic [ADDR_W-1:0] feature_baseaddr;
        logic [ADDR_W-1:0] kernel_baseaddr;
        logic [ADDR_W-1:0] output_baseaddr;
        logic [DATA_W-1:0] feature_width;
        logic [DATA_W-1:0] feature_height;
        logic [DATA_W-1:0] feature_chin;
        logic [DATA_W-1:0] feature_chout;
        logic [7:0]        kernel_sizeh;
        logic [7:0]        kernel_sizew;
        logic [7:0]        stride;
        logic              has_bias;
        logic              has_relu;
        logic [DATA_W-1:0] output_width;
        logic [DATA_W-1:0] output_height;
        logic              chain;
    } layer_cmd_t;

endpackage

// File: rtl/layer_cmd_fifo.sv
// Show-ahead command FIFO with flush and occupancy level.
module layer_cmd_fifo
    import npu_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  layer_cmd_t               din,
    input  logic                     pop,
    input  logic                     flush,
    output layer_cmd_t               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [$clog2(DEPTH):0]   level_nxt_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    layer_cmd_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push_ok;
    logic            pop_ok;

    // A push while full is dropped even if a pop happens in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign head    = mem[rd_ptr];

    // Next occupancy, also used by the parent to register busy.
    always_comb begin
        level_nxt_c = level;
        if (flush) begin
            level_nxt_c = '0;
        end else begin
            level_nxt_c = level + LW'(push_ok) - LW'(pop_ok);
        end
    end

    // Pointer and level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            level <= level_nxt_c;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/layer_sched.sv
// Layer scheduler: queues host layer commands, issues them to the instruction
// generator and tracks completion by counting output-pixel writebacks.
// Optional feature macro LAYER_SCHED_CHAIN_EN: chained layers read their input
// feature map from the previous layer's output base address.
module layer_sched
    import npu_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  layer_cmd_t              cmd,
    output layer_cmd_t              ig_cmd,
    output logic                    csrcmd_valid,
    input  logic                    instgen_ready,
    input  logic                    wb_done,
    input  logic                    soft_clr,
    input  logic                    irq_clr,
    output logic                    busy,
    output logic                    layer_done,
    output logic                    irq,
    output logic                    err_spurious,
    output logic [LCNT_W-1:0]       layers_completed,
    output logic [$clog2(DEPTH):0]  queue_level
);

    sched_state_t              state;
    sched_state_t              state_d;
    layer_cmd_t                fifo_head;
    layer_cmd_t                issue_cmd_c;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [$clog2(DEPTH):0]    level_nxt;
    logic                      pop;
    logic                      flush;
    logic                      hs;
    logic                      csrcmd_valid_d;
    logic                      layer_done_d;
    logic                      busy_d;
    logic [DATA_W-1:0]         expected;
    logic [DATA_W-1:0]         pix_cnt;
`ifdef LAYER_SCHED_CHAIN_EN
    logic [ADDR_W-1:0]         last_out;
`endif

    layer_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (cmd_valid),
        .din         (cmd),
        .pop         (pop),
        .flush       (flush),
        .head        (fifo_head),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .level       (queue_level),
        .level_nxt_c (level_nxt)
    );

    assign cmd_ready = !fifo_full;
    assign hs        = csrcmd_valid && instgen_ready;

    // Command presented downstream; chained layers take the last output base.
    always_comb begin
        issue_cmd_c = fifo_head;
`ifdef LAYER_SCHED_CHAIN_EN
        if (fifo_head.chain) issue_cmd_c.feature_baseaddr = last_out;
`endif
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d        = state;
        pop            = 1'b0;
        flush          = 1'b0;
        case (state)
            IDLE: begin
                if (soft_clr) begin
                    flush = 1'b1;
                end else if (!fifo_empty) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (hs) begin
                    pop     = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (pix_cnt == expected) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        csrcmd_valid_d = (state == ISSUE) && !hs;
        layer_done_d   = (state_d == DONE);
        busy_d         = (state_d != IDLE) || (level_nxt != '0);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csrcmd_valid <= 1'b0;
            layer_done   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            csrcmd_valid <= csrcmd_valid_d;
            layer_done   <= layer_done_d;
            busy         <= busy_d;
        end
    end

    // Latch the head on ISSUE entry so ig_cmd holds until the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ig_cmd <= '0;
        end else if ((state == ISSUE) && !csrcmd_valid) begin
            ig_cmd <= issue_cmd_c;
        end
    end

    // Pixel target and writeback counter for the running layer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expected <= '0;
            pix_cnt  <= '0;
        end else if (hs) begin
            expected <= DATA_W'(ig_cmd.output_width * ig_cmd.output_height);
            pix_cnt  <= '0;
        end else if ((state == RUN) && wb_done) begin
            pix_cnt <= pix_cnt + DATA_W'(1);
        end
    end

    // Completed-layer counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              layers_completed <= '0;
        else if (state == DONE)  layers_completed <= layers_completed + LCNT_W'(1);
    end

    // Sticky flags; a set in the same cycle as irq_clr wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq          <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            if ((state == DONE) && fifo_empty) irq <= 1'b1;
            else if (irq_clr)                  irq <= 1'b0;
            if (wb_done && (state != RUN))     err_spurious <= 1'b1;
            else if (irq_clr)                  err_spurious <= 1'b0;
        end
    end

`ifdef LAYER_SCHED_CHAIN_EN
    // Output base of the most recently issued layer, for chaining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   last_out <= '0;
        else if (hs)  last_out <= ig_cmd.output_baseaddr;
    end
`endif

endmodule
